turmite_fsm: RTL
================

TURMITE_FSM -- requirements
Module: turmite_fsm

Interface
REQ-001 C_NUM_OF_CELLS_X, default 5: grid width in cells, range 2..256.
REQ-002 C_NUM_OF_CELLS_Y, default 5: grid height in cells, range 2..256; X*Y SHALL NOT exceed 65536.
REQ-003 C_NUM_ANTS, default 1: number of ants, range 1..8.
REQ-004 C_NUM_COLORS, default 2: cell colours, range 2..16; CW = max(1, $clog2(C_NUM_COLORS)).
REQ-005 C_RULE, default 16'h0001: bit c = 1 means turn right on colour c; bit c = 0 means turn left.
REQ-006 XW = max(1, $clog2(C_NUM_OF_CELLS_X)) and YW = max(1, $clog2(C_NUM_OF_CELLS_Y)) SHALL be derived localparams.
REQ-007 iclk  in  1  the single clock; all logic is on its rising edge.
REQ-008 irst  in  1  synchronous, active-high reset.
REQ-009 istart  in  1  level; leaves IDLE.
REQ-010 istep  in  1  level; a rising edge requests one generation.
REQ-011 iline  in  YW  display row for pass-through read address.
REQ-012 icolumn  in  XW  display column for pass-through read address.
REQ-013 oaddr_rd  out  16  cell memory read address; memory returns ird_data one cycle later.
REQ-014 ird_data  in  CW  colour at the previous cycle's oaddr_rd.
REQ-015 oaddr_wr  out  16  write address.
REQ-016 owr_en  out  1  one-cycle write strobe.
REQ-017 owr_data  out  CW  write colour.
REQ-018 opos_x  out  C_NUM_ANTS*XW  packed ant x positions; ant k occupies [k*XW +: XW].
REQ-019 opos_y  out  C_NUM_ANTS*YW  packed ant y positions.
REQ-020 odir  out  C_NUM_ANTS*2  packed directions: up=0, down=1, left=2, right=3.
REQ-021 obusy  out  1  high from generation start until odone.
REQ-022 odone  out  1  one-cycle pulse when a generation completes.
REQ-023 ogen  out  16  completed-generation counter.

Function
REQ-024 Cell address SHALL be computed as y*C_NUM_OF_CELLS_X + x, zero-extended to 16 bits.
REQ-025 States: IDLE, WAIT, RD, RDW, TURN, WR, MOVE, NEXT, HOLD.
REQ-026 IDLE: initialise ant k to x=(X/2+k) mod X, y=Y/2, direction left; set ant index=0 and ogen=0; go to WAIT when istart=1.
REQ-027 WAIT: drive oaddr_rd = iline*X + icolumn every cycle; on an istep rising edge (istep=1, registered previous value 0) set obusy=1 and go to RD.
REQ-028 RD: drive oaddr_rd with the current ant's cell address; go to RDW.
REQ-029 RDW: go to TURN, so that ird_data is sampled exactly one cycle after the address.
REQ-030 TURN: latch colour c = ird_data.
REQ-031 TURN: rotate right if C_RULE[c]=1, otherwise rotate left.
REQ-032 TURN: right rotation maps up->right->down->left->up; left rotation is the inverse.
REQ-033 WR: owr_en=1 for exactly one cycle.
REQ-034 WR: oaddr_wr = current ant's cell; owr_data = (c+1) mod C_NUM_COLORS.
REQ-035 MOVE: step one cell in the new direction (up = y-1, down = y+1, left = x-1, right = x+1).
REQ-036 MOVE: wrap toroidally: x 0 moving left -> X-1; x X-1 moving right -> 0; same rule for y with Y.
REQ-037 NEXT: if index < C_NUM_ANTS-1, increment the index and go to RD.
REQ-038 NEXT: otherwise clear the index, increment ogen (wrapping at 65535 -> 0), pulse odone, clear obusy and go to HOLD.
REQ-039 HOLD: return to WAIT when istep=0.
REQ-040 Ants are processed strictly in index order; the write for ant k completes before the read for ant k+1.
REQ-041 Ants sharing a cell therefore see each other's updates.
REQ-042 A rising edge of istep while obusy=1 SHALL be ignored.
REQ-043 istart SHALL be ignored outside IDLE.
REQ-044 Out-of-range iline/icolumn SHALL NOT be clamped.

Reset
REQ-045 irst=1 at a clock edge SHALL force state IDLE and owr_en, odone and obusy to 0.
REQ-046 irst=1 SHALL set oaddr_rd, oaddr_wr, owr_data and ogen to 0, and load the initial ant positions and directions.
REQ-047 Reset mid-generation SHALL abort the generation with no further write; a write already issued is not undone.
REQ-048 Cell memory contents are not cleared by this block.

Verification
REQ-049 5x5, 1 ant, memory all 0, istart, one istep pulse -> single write addr 12 data 1; ant moves to (2,1) facing up; odone pulse; ogen=1.
REQ-050 4x2, 1 ant, 5 step pulses -> positions (2,0),(3,0),(3,1),(2,1), then y wraps to give (2,0) facing down; 5th write addr 6 data 0.
REQ-051 5x5, 3 colours, C_RULE=16'h0003, cell 12 preset to 2 -> first step writes 0 to addr 12, turns left from left to down, ant moves to (2,3).
REQ-052 5x5, 2 ants, memory 0, one step -> ant0 writes addr 12, ant1 writes addr 13, in that order; odone after both; obusy high throughout.
REQ-053 istep toggled while obusy=1 -> no extra generation; irst asserted in state TURN -> no write, state IDLE, ogen=0.
REQ-054 In WAIT with iline=3, icolumn=4 on 5x5 -> oaddr_rd=19 on the following cycle.

Source files
------------

// File: rtl/turmite_fsm.sv
// Multi-ant turmite on a toroidal grid held in an external cell memory.
// Ants update one at a time: read cell, turn by rule, recolour cell, step.
module turmite_fsm #(
  parameter int unsigned C_NUM_OF_CELLS_X = 5,
  parameter int unsigned C_NUM_OF_CELLS_Y = 5,
  parameter int unsigned C_NUM_ANTS       = 1,
  parameter int unsigned C_NUM_COLORS     = 2,
  parameter logic [15:0] C_RULE           = 16'h0001,
  localparam int unsigned XW = ($clog2(C_NUM_OF_CELLS_X) < 1) ? 1 : $clog2(C_NUM_OF_CELLS_X),
  localparam int unsigned YW = ($clog2(C_NUM_OF_CELLS_Y) < 1) ? 1 : $clog2(C_NUM_OF_CELLS_Y),
  localparam int unsigned CW = ($clog2(C_NUM_COLORS) < 1) ? 1 : $clog2(C_NUM_COLORS)
) (
  input  logic                     iclk,
  input  logic                     irst,
  input  logic                     istart,
  input  logic                     istep,
  input  logic [YW-1:0]            iline,
  input  logic [XW-1:0]            icolumn,
  output logic [15:0]              oaddr_rd,
  input  logic [CW-1:0]            ird_data,
  output logic [15:0]              oaddr_wr,
  output logic                     owr_en,
  output logic [CW-1:0]            owr_data,
  output logic [C_NUM_ANTS*XW-1:0] opos_x,
  output logic [C_NUM_ANTS*YW-1:0] opos_y,
  output logic [C_NUM_ANTS*2-1:0]  odir,
  output logic                     obusy,
  output logic                     odone,
  output logic [15:0]              ogen
);

  localparam int unsigned IW = ($clog2(C_NUM_ANTS) < 1) ? 1 : $clog2(C_NUM_ANTS);
  localparam logic [IW-1:0] LAST_ANT = IW'(C_NUM_ANTS - 1);
  localparam logic [XW-1:0] X_MAX    = XW'(C_NUM_OF_CELLS_X - 1);
  localparam logic [YW-1:0] Y_MAX    = YW'(C_NUM_OF_CELLS_Y - 1);
  localparam logic [CW-1:0] C_MAX    = CW'(C_NUM_COLORS - 1);
  localparam logic [1:0] D_UP = 2'd0, D_DOWN = 2'd1, D_LEFT = 2'd2, D_RIGHT = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT, S_RD, S_RDW, S_TURN, S_WR, S_MOVE, S_NEXT, S_HOLD
  } state_t;

  state_t                    r_state;
  logic [C_NUM_ANTS*XW-1:0]  r_x;
  logic [C_NUM_ANTS*YW-1:0]  r_y;
  logic [C_NUM_ANTS*2-1:0]   r_dir;
  logic [IW-1:0]             r_idx;
  logic [CW-1:0]             r_color;
  logic                      r_step_prev;
  logic [15:0]               r_addr_rd;
  logic [15:0]               r_addr_wr;
  logic                      r_wr_en;
  logic [CW-1:0]             r_wr_data;
  logic                      r_busy;
  logic                      r_done;
  logic [15:0]               r_gen;

  logic [XW-1:0] w_cx;
  logic [YW-1:0] w_cy;
  logic [1:0]    w_cdir;
  logic [1:0]    w_turned;
  logic [XW-1:0] w_nx;
  logic [YW-1:0] w_ny;
  logic [15:0]   w_caddr;
  logic [15:0]   w_disp_addr;
  logic [CW-1:0] w_next_color;

  function automatic logic [XW-1:0] init_x(input int unsigned k);
    return XW'((C_NUM_OF_CELLS_X / 2 + k) % C_NUM_OF_CELLS_X);
  endfunction

  // Current-ant view, turn decision, toroidal step and next colour
  always_comb begin
    w_cx         = r_x[32'(r_idx) * XW +: XW];
    w_cy         = r_y[32'(r_idx) * YW +: YW];
    w_cdir       = r_dir[32'(r_idx) * 2 +: 2];
    w_caddr      = 16'(w_cy) * 16'(C_NUM_OF_CELLS_X) + 16'(w_cx);
    w_disp_addr  = 16'(iline) * 16'(C_NUM_OF_CELLS_X) + 16'(icolumn);
    w_next_color = (r_color == C_MAX) ? '0 : r_color + CW'(1);
    w_nx         = w_cx;
    w_ny         = w_cy;
    w_turned     = w_cdir;
    if (C_RULE[ird_data]) begin
      case (w_cdir)
        D_UP:    w_turned = D_RIGHT;
        D_RIGHT: w_turned = D_DOWN;
        D_DOWN:  w_turned = D_LEFT;
        default: w_turned = D_UP;
      endcase
    end else begin
      case (w_cdir)
        D_UP:    w_turned = D_LEFT;
        D_LEFT:  w_turned = D_DOWN;
        D_DOWN:  w_turned = D_RIGHT;
        default: w_turned = D_UP;
      endcase
    end
    case (w_cdir)
      D_UP:    w_ny = (w_cy == '0)    ? Y_MAX : w_cy - YW'(1);
      D_DOWN:  w_ny = (w_cy == Y_MAX) ? '0    : w_cy + YW'(1);
      D_LEFT:  w_nx = (w_cx == '0)    ? X_MAX : w_cx - XW'(1);
      default: w_nx = (w_cx == X_MAX) ? '0    : w_cx + XW'(1);
    endcase
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_color     <= '0;
      r_step_prev <= 1'b0;
      r_addr_rd   <= '0;
      r_addr_wr   <= '0;
      r_wr_en     <= 1'b0;
      r_wr_data   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_gen       <= '0;
      for (int unsigned k = 0; k < C_NUM_ANTS; k++) begin
        r_x[k*XW +: XW] <= init_x(k);
        r_y[k*YW +: YW] <= YW'(C_NUM_OF_CELLS_Y / 2);
        r_dir[k*2 +: 2] <= D_LEFT;
      end
    end else begin
      r_step_prev <= istep;
      r_wr_en     <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          for (int unsigned k = 0; k < C_NUM_ANTS; k++) begin
            r_x[k*XW +: XW] <= init_x(k);
            r_y[k*YW +: YW] <= YW'(C_NUM_OF_CELLS_Y / 2);
            r_dir[k*2 +: 2] <= D_LEFT;
          end
          r_idx <= '0;
          r_gen <= '0;
          if (istart) r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_addr_rd <= w_disp_addr;
          if (istep && !r_step_prev) begin
            r_busy  <= 1'b1;
            r_state <= S_RD;
          end
        end
        S_RD: begin
          r_addr_rd <= w_caddr;
          r_state   <= S_RDW;
        end
        // Memory answers one cycle after the address appears
        S_RDW: r_state <= S_TURN;
        S_TURN: begin
          r_color                     <= ird_data;
          r_dir[32'(r_idx) * 2 +: 2]  <= w_turned;
          r_state                     <= S_WR;
        end
        S_WR: begin
          r_wr_en   <= 1'b1;
          r_addr_wr <= w_caddr;
          r_wr_data <= w_next_color;
          r_state   <= S_MOVE;
        end
        S_MOVE: begin
          r_x[32'(r_idx) * XW +: XW] <= w_nx;
          r_y[32'(r_idx) * YW +: YW] <= w_ny;
          r_state                    <= S_NEXT;
        end
        S_NEXT: begin
          if (r_idx != LAST_ANT) begin
            r_idx   <= r_idx + IW'(1);
            r_state <= S_RD;
          end else begin
            r_idx   <= '0;
            r_gen   <= r_gen + 16'd1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: if (!istep) r_state <= S_WAIT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign oaddr_rd = r_addr_rd;
  assign oaddr_wr = r_addr_wr;
  assign owr_en   = r_wr_en;
  assign owr_data = r_wr_data;
  assign opos_x   = r_x;
  assign opos_y   = r_y;
  assign odir     = r_dir;
  assign obusy    = r_busy;
  assign odone    = r_done;
  assign ogen     = r_gen;

endmodule
